// File: rtl/tdm_slot_collector_if.sv
// Bundle between the TDM deserialiser, the slot collector and the host read side.
interface tdm_slot_collector_if #(
  parameter int DW  = 8,
  parameter int TSW = 5,
  parameter int CW  = 8
);
  logic [DW-1:0]  pdata;
  logic [TSW-1:0] timeslot;
  logic           par_ok;
  logic           rd_en;
  logic [TSW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic           rd_err;
  logic           rd_valid;
  logic           locked;
  logic           frame_done;
  logic [CW-1:0]  frame_cnt;
  logic [CW-1:0]  par_err_cnt;
  logic [CW-1:0]  slip_cnt;

  modport master (
    output pdata, timeslot, par_ok, rd_en, rd_addr,
    input  rd_data, rd_err, rd_valid, locked, frame_done,
           frame_cnt, par_err_cnt, slip_cnt
  );

  modport slave (
    input  pdata, timeslot, par_ok, rd_en, rd_addr,
    output rd_data, rd_err, rd_valid, locked, frame_done,
           frame_cnt, par_err_cnt, slip_cnt
  );
endinterface

// File: rtl/tdm_slot_collector.sv
// Slot-sequence checker and frame buffer behind the TDM deserialiser.
// A byte is captured whenever the timeslot number changes.
module tdm_slot_collector #(
  parameter int DW  = 8,
  parameter int TSW = 5,
  parameter int CW  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  tdm_slot_collector_if.slave  bus
);
  localparam int NS = 2**TSW;

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t         state;
  logic [TSW-1:0] ts_prev;
  logic [DW-1:0]  mem [NS];
  logic [NS-1:0]  err;

  logic evt, in_seq, wr, slip;

  assign evt    = bus.timeslot != ts_prev;
  assign in_seq = bus.timeslot == TSW'(ts_prev + 1'b1);
  assign slip   = evt && (state == LOCKED) && !in_seq;

  // Slot 0 is always a valid anchor: it locks from HUNT and survives a slip.
  always_comb begin
    wr = 1'b0;
    if (evt) begin
      if (state == HUNT) wr = (bus.timeslot == '0);
      else               wr = in_seq || (bus.timeslot == '0);
    end
  end

  // Frame storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr) mem[bus.timeslot] <= bus.pdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= HUNT;
      bus.locked      <= 1'b0;
      ts_prev         <= '0;
      err             <= '0;
      bus.frame_done  <= 1'b0;
      bus.frame_cnt   <= '0;
      bus.par_err_cnt <= '0;
      bus.slip_cnt    <= '0;
      bus.rd_valid    <= 1'b0;
      bus.rd_data     <= '0;
      bus.rd_err      <= 1'b0;
    end else begin
      ts_prev        <= bus.timeslot;
      bus.frame_done <= 1'b0;

      case (state)
        HUNT: begin
          if (wr) begin
            state      <= LOCKED;
            bus.locked <= 1'b1;
          end
        end
        LOCKED: begin
          if (slip && bus.timeslot != '0) begin
            state      <= HUNT;
            bus.locked <= 1'b0;
          end
          if (evt && in_seq && bus.timeslot == '1) begin
            bus.frame_done <= 1'b1;
            bus.frame_cnt  <= bus.frame_cnt + 1'b1;
          end
        end
        default: begin
          state      <= HUNT;
          bus.locked <= 1'b0;
        end
      endcase

      if (slip && bus.slip_cnt != '1) bus.slip_cnt <= bus.slip_cnt + 1'b1;

      if (wr) begin
        err[bus.timeslot] <= ~bus.par_ok;
        if (!bus.par_ok && bus.par_err_cnt != '1)
          bus.par_err_cnt <= bus.par_err_cnt + 1'b1;
      end

      // Read-before-write: the nonblocking update of mem/err lands after this sample.
      bus.rd_valid <= bus.rd_en;
      if (bus.rd_en) begin
        bus.rd_data <= mem[bus.rd_addr];
        bus.rd_err  <= err[bus.rd_addr];
      end
    end
  end
endmodule

// File: tb/tb_tdm_slot_collector.sv
// Directed bench for tdm_slot_collector with a slot-level reference model.
module tb_tdm_slot_collector;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tdm_slot_collector_if #(.DW(8), .TSW(5), .CW(8)) bus ();

  tdm_slot_collector #(.DW(8), .TSW(5), .CW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: frame buffer contents plus which slots hold known data.
  int m_buf [32];
  bit m_err [32];
  bit m_known [32];
  int m_prev, m_frames, m_par, m_slips;
  bit m_locked;
  int e_rd_data;
  bit e_rd_err, e_rd_valid, e_known, e_frame_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_prev = 0; m_frames = 0; m_par = 0; m_slips = 0; m_locked = 0;
    e_rd_data = 0; e_rd_err = 0; e_rd_valid = 0; e_known = 1; e_frame_done = 0;
    for (int i = 0; i < 32; i++) m_err[i] = 0;
  endfunction

  // Outputs expected after one clock edge with the given inputs.
  function automatic void model_clk(int ts, int pd, bit ok, bit rden, int ra);
    bit w;
    e_rd_valid = rden;
    if (rden) begin
      e_rd_data = m_buf[ra]; e_rd_err = m_err[ra]; e_known = m_known[ra];
    end
    e_frame_done = 0;
    w = 0;
    if (ts != m_prev) begin
      if (!m_locked) begin
        if (ts == 0) begin w = 1; m_locked = 1; end
      end else if (ts == (m_prev + 1) % 32) begin
        w = 1;
        if (ts == 31) begin e_frame_done = 1; m_frames = (m_frames + 1) % 256; end
      end else begin
        if (m_slips < 255) m_slips++;
        if (ts == 0) w = 1; else m_locked = 0;
      end
      if (w) begin
        m_buf[ts] = pd; m_err[ts] = !ok; m_known[ts] = 1;
        if (!ok && m_par < 255) m_par++;
      end
    end
    m_prev = ts;
  endfunction

  task automatic step(input int ts, input int pd, input bit ok,
                      input bit rden = 0, input int ra = 0);
    bus.timeslot = 5'(ts); bus.pdata = 8'(pd); bus.par_ok = ok;
    bus.rd_en = rden; bus.rd_addr = 5'(ra);
    model_clk(ts, pd, ok, rden, ra);
    @(posedge clk); #1;
    chk("locked", 32'(bus.locked), 32'(m_locked));
    chk("frame_done", 32'(bus.frame_done), 32'(e_frame_done));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_frames));
    chk("par_err_cnt", 32'(bus.par_err_cnt), 32'(m_par));
    chk("slip_cnt", 32'(bus.slip_cnt), 32'(m_slips));
    chk("rd_valid", 32'(bus.rd_valid), 32'(e_rd_valid));
    if (e_known) begin
      chk("rd_data", 32'(bus.rd_data), 32'(e_rd_data));
      chk("rd_err", 32'(bus.rd_err), 32'(e_rd_err));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_locked"}, 32'(bus.locked), 0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_rd_valid"}, 32'(bus.rd_valid), 0);
    chk({tag, "_rd_data"}, 32'(bus.rd_data), 0);
    chk({tag, "_rd_err"}, 32'(bus.rd_err), 0);
    chk({tag, "_counts"}, {8'h0, bus.frame_cnt, bus.par_err_cnt, bus.slip_cnt}, 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1; #1;
    chk_zero(tag);
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_buf[i] = 0; m_known[i] = 0; end
    bus.timeslot = '0; bus.pdata = '0; bus.par_ok = 1'b1;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    model_reset();
    do_reset("rst0");

    // Clean frame entered from slot 31, then read back every slot.
    step(31, 0, 1);
    chk("t1_hunt", 32'(bus.locked), 0);
    step(0, 0, 1);
    chk("t1_lock_rise", 32'(bus.locked), 1);
    for (int s = 1; s < 32; s++) step(s, s * 3, 1);
    chk("t1_frame_done", 32'(bus.frame_done), 1);
    chk("t1_frame_cnt", 32'(bus.frame_cnt), 1);
    chk("t1_par_err", 32'(bus.par_err_cnt), 0);
    for (int s = 0; s < 32; s++) begin
      step(31, 0, 1, 1, s);
      chk("t1_rd_data", 32'(bus.rd_data), 32'(s * 3));
      chk("t1_rd_valid", 32'(bus.rd_valid), 1);
    end
    step(31, 0, 1);
    chk("t1_rd_valid_low", 32'(bus.rd_valid), 0);
    chk("t1_rd_hold", 32'(bus.rd_data), 93);

    // Start mid-frame: nothing is captured or counted until slot 0.
    do_reset("rst2");
    for (int s = 5; s < 32; s++) step(s, 8'hEE, 0);
    chk("t2_hunt_par", 32'(bus.par_err_cnt), 0);
    chk("t2_hunt_locked", 32'(bus.locked), 0);
    step(0, 8'h40, 1);
    chk("t2_locked", 32'(bus.locked), 1);
    chk("t2_slip", 32'(bus.slip_cnt), 0);

    // Slip to a non-zero slot drops lock; broken frame never completes.
    do_reset("rst3");
    step(31, 0, 1);
    for (int s = 0; s < 10; s++) step(s, s + 100, 1);
    step(14, 8'h77, 1);
    chk("t3_slip", 32'(bus.slip_cnt), 1);
    chk("t3_unlock", 32'(bus.locked), 0);
    for (int s = 15; s < 32; s++) step(s, s, 1);
    chk("t3_no_frame", 32'(bus.frame_cnt), 0);
    step(0, 8'h55, 1);
    chk("t3_relock", 32'(bus.locked), 1);

    // Slip back to slot 0 keeps lock and rewrites slot 0.
    do_reset("rst4");
    step(31, 0, 1);
    for (int s = 0; s <= 20; s++) step(s, s, 1);
    step(0, 8'hC3, 1);
    chk("t4_slip", 32'(bus.slip_cnt), 1);
    chk("t4_locked", 32'(bus.locked), 1);
    for (int s = 1; s < 32; s++) step(s, s, 1);
    chk("t4_frame", 32'(bus.frame_cnt), 1);
    step(31, 0, 1, 1, 0);
    chk("t4_buf0", 32'(bus.rd_data), 32'h0C3);

    // Parity errors on slots 3 and 17 only.
    do_reset("rst5");
    step(31, 0, 1);
    for (int s = 0; s < 32; s++) step(s, s, !(s == 3 || s == 17));
    chk("t5_par", 32'(bus.par_err_cnt), 2);
    for (int s = 0; s < 32; s++) begin
      step(31, 0, 1, 1, s);
      chk("t5_rd_err", 32'(bus.rd_err), 32'(s == 3 || s == 17));
    end

    // 300 all-bad frames: parity count saturates, frame count wraps.
    do_reset("rst6");
    step(31, 0, 1);
    for (int f = 0; f < 300; f++)
      for (int s = 0; s < 32; s++) step(s, s * 3, 0);
    chk("t6_par_sat", 32'(bus.par_err_cnt), 255);
    chk("t6_frame_wrap", 32'(bus.frame_cnt), 44);

    // Read-before-write collision on slot 7, then reset cancelling pulses.
    do_reset("rst7");
    step(31, 0, 1);
    for (int s = 0; s < 32; s++) step(s, (s == 7) ? 8'h15 : s, 1);
    for (int s = 0; s < 7; s++) step(s, s, 1);
    step(7, 8'hA5, 1, 1, 7);
    chk("t7_old", 32'(bus.rd_data), 32'h15);
    step(8, 8, 1, 1, 7);
    chk("t7_new", 32'(bus.rd_data), 32'hA5);
    for (int s = 9; s < 31; s++) step(s, s, 1);
    step(31, 31, 1, 1, 0);
    chk("t7_fd_before_rst", 32'(bus.frame_done), 1);
    chk("t7_rv_before_rst", 32'(bus.rd_valid), 1);
    do_reset("rst_mid");
    step(1, 1, 1);
    step(2, 2, 1);
    chk("t7_rehunt", 32'(bus.locked), 0);
    step(0, 0, 1);
    chk("t7_relock", 32'(bus.locked), 1);
    step(0, 0, 1);
    step(0, 0, 1);
    chk("t7_stuck_slot", 32'(bus.slip_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tdm_slot_collector.md
Name: tdm_slot_collector

Overview:
- Receive-side stage directly downstream of the TDM destination deserialiser.
- Consumes the recovered parallel byte, its timeslot number and the parity-check flag.
- Verifies slot sequencing, stores each byte with its parity status in a 32-entry frame buffer, and counts frames, parity errors and slot slips.
- Exposes a random-access read port for the downstream host logic.

Parameters:
DW, 8, data byte width
TSW, 5, timeslot number width; number of slots is 2**TSW (32)
CW, 8, width of the frame, parity-error and slip counters

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
pdata  in  DW  recovered byte from the deserialiser
timeslot  in  TSW  slot number of pdata
par_ok  in  1  1 = parity of current byte matched
rd_en  in  1  read request
rd_addr  in  TSW  slot to read
rd_data  out  DW  stored byte for rd_addr
rd_err  out  1  stored parity-error flag for rd_addr
rd_valid  out  1  rd_data/rd_err valid, one cycle after rd_en
locked  out  1  slot sequence aligned
frame_done  out  1  one-cycle pulse, full frame 0..31 captured
frame_cnt  out  CW  completed frames, wraps
par_err_cnt  out  CW  bytes captured with par_ok=0, saturates
slip_cnt  out  CW  sequence violations, saturates

Behaviour:
- Reset values:
  - All outputs and counters are 0. State is HUNT.
  - The internal ts_prev register is 0.
  - Buffer contents are not cleared, but the per-slot error bits are cleared to 0.
- Capture event (evt):
  - Occurs on a cycle where timeslot != ts_prev.
  - On that cycle the block samples pdata and par_ok as the completed byte for slot timeslot.
  - ts_prev <= timeslot every cycle.
- State HUNT:
  - locked=0.
  - An evt with timeslot==0 writes buf[0] and err[0]=~par_ok, then goes to LOCKED.
  - All other evts are ignored and not counted.
- State LOCKED:
  - locked=1.
  - Evt with timeslot == ts_prev+1 (mod 32): write buf[timeslot] and err[timeslot]=~par_ok.
  - Evt with any other slot number is a slip:
    - slip_cnt+1.
    - If timeslot==0, the byte is written and the state stays LOCKED.
    - Otherwise the byte is discarded and the state goes to HUNT; locked falls on the next cycle.
- Parity:
  - Each write with par_ok=0 increments par_err_cnt.
  - Bytes discarded in HUNT are never counted.
- Frame completion:
  - A write of slot 31 in LOCKED, in sequence from 30, sets frame_done=1 for exactly the next cycle and increments frame_cnt (wraps 255->0).
  - A frame interrupted by a slip produces no frame_done.
- Counters:
  - par_err_cnt and slip_cnt saturate at 2**CW-1.
  - frame_cnt wraps.
- Read port:
  - Synchronous, latency 1: rd_en at cycle n gives rd_data, rd_err and rd_valid=1 at n+1.
  - rd_valid=0 when rd_en was 0; rd_data holds its last value.
  - A read and a write to the same slot in the same cycle return the old contents (read-before-write).
  - Reads are allowed in any state.
- Reset mid-operation:
  - Asynchronous clear to the reset values above.
  - Any in-flight frame_done or rd_valid is cancelled.
  - After release, the block re-hunts for slot 0.
- Change detection:
  - A timeslot held constant for many cycles produces exactly one evt.
  - A stuck slot number never re-captures.

Test Plan:
- Sequence 31->0->1..31 with pdata=slot*3 and par_ok=1 -> locked rises the cycle after slot 0. frame_done pulses once after slot 31. frame_cnt=1, par_err_cnt=0. Reading slots 0..31 returns slot*3 with rd_err=0, rd_valid one cycle after each rd_en.
- Start after reset at slot 5 (5,6,...,31,0) -> no writes and no counts until slot 0, then locked=1. slip_cnt=0.
- Locked run 0..9, then jump to slot 14 -> slip_cnt=1, locked=0 next cycle, byte for 14 discarded. Relocks at the next slot 0. No frame_done for the broken frame.
- Locked run 0..20, then slot 0 -> slip_cnt=1, locked stays 1, buf[0] rewritten. A subsequent full 1..31 run gives frame_done.
- Full frame with par_ok=0 on slots 3 and 17 -> par_err_cnt=2, rd_err=1 only at addresses 3 and 17. 300 frames of all-bad parity -> par_err_cnt saturates at 255 and frame_cnt wraps to 44.
- rd_en to slot 7 in the same cycle slot 7 is written with 0xA5 (old value 0x15) -> rd_data=0x15. The next read returns 0xA5. Asserting reset mid-frame -> all outputs 0 immediately and re-hunt.
